// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: valid/ready handshake with optional skid entry,
// control field forced safe on bubble/flush, saturating backpressure counter.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W            = 96,
  parameter int unsigned       CTRL_W            = 16,
  parameter logic [CTRL_W-1:0] CTRL_RESET        = '0,
  parameter bit                SKID_EN           = 1'b1,
  parameter bit                FLUSH_CLEARS_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [15:0]       stall_cycles
);

  localparam int unsigned OCC_W   = 2;
  localparam int unsigned STALL_W = 16;

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [OCC_W-1:0]  occ_q,        occ_d;
  logic [STALL_W-1:0] stall_q,     stall_d;

  logic in_xfer;
  logic main_load;

  // With a skid entry, in_ready depends only on registered state.
  always_comb begin
    in_ready = 1'b0;
    if (!reset && enable && !flush) begin
      if (SKID_EN) in_ready = !skid_valid_q;
      else         in_ready = !main_valid_q || out_ready;
    end
  end

  assign in_xfer   = in_valid && in_ready;
  assign main_load = !main_valid_q || out_ready;

  // Next-state: flush beats advance; skid drains into main before new input.
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    stall_d      = stall_q;
    if (enable) begin
      if (flush) begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
        main_ctrl_d  = CTRL_RESET;
        if (FLUSH_CLEARS_DATA) begin
          main_data_d = '0;
          skid_data_d = '0;
        end
      end else begin
        if (main_load) begin
          if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_ctrl_d  = skid_ctrl_q;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
          end else if (in_xfer) begin
            main_valid_d = 1'b1;
            main_ctrl_d  = in_ctrl;
            main_data_d  = in_data;
          end else begin
            main_valid_d = 1'b0;
            main_ctrl_d  = CTRL_RESET;
          end
        end else if (in_xfer && SKID_EN) begin
          skid_valid_d = 1'b1;
          skid_ctrl_d  = in_ctrl;
          skid_data_d  = in_data;
        end
        if (main_valid_q && !out_ready && (stall_q != '1)) begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
    end
    occ_d = OCC_W'(main_valid_d) + OCC_W'(skid_valid_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= CTRL_RESET;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      occ_q        <= '0;
      stall_q      <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      occ_q        <= occ_d;
      stall_q      <= stall_d;
    end
  end

  assign out_valid    = main_valid_q;
  assign out_ctrl     = main_ctrl_q;
  assign out_data     = main_data_q;
  assign occupancy    = occ_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the skid instance is modelled as a bounded FIFO,
// the single-entry instance gets a short directed check.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 96;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] CRST = 16'hA5A5;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0] occupancy;
  logic [15:0] stall_cycles;

  logic s_valid = 1'b0;
  logic s_ready;
  logic [CW-1:0] s_ctrl = '0;
  logic [DW-1:0] s_data = '0;
  logic s_ovalid;
  logic s_ordy = 1'b1;
  logic [CW-1:0] s_octrl;
  logic [DW-1:0] s_odata;
  logic [1:0] s_occ;
  logic [15:0] s_stall;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RESET(CRST), .SKID_EN(1'b1),
                   .FLUSH_CLEARS_DATA(1'b0)) u_skid (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cycles(stall_cycles));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RESET(16'h0000), .SKID_EN(1'b0),
                   .FLUSH_CLEARS_DATA(1'b0)) u_single (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .in_valid(s_valid), .in_ready(s_ready), .in_ctrl(s_ctrl), .in_data(s_data),
    .out_valid(s_ovalid), .out_ready(s_ordy), .out_ctrl(s_octrl), .out_data(s_odata),
    .occupancy(s_occ), .stall_cycles(s_stall));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int seq = 0;

  // Reference model: entries held by the stage, oldest first.
  ent_t exp_q[$];
  ent_t pend;
  logic pend_v = 1'b0;
  logic [15:0] stall_m = '0;
  logic [DW-1:0] last_data = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [CW-1:0] c);
    ent_t e;
    seq++;
    e.c = c;
    e.d = {32'(seq), $urandom, $urandom};
    return e;
  endfunction

  // State checks just after each edge.
  always @(posedge clk) begin
    #2;
    chk("occupancy", 128'(occupancy), 128'(exp_q.size()));
    chk("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
    chk("out_ctrl", 128'(out_ctrl), 128'((exp_q.size() > 0) ? exp_q[0].c : CRST));
    chk("out_data", 128'(out_data), 128'((exp_q.size() > 0) ? exp_q[0].d : last_data));
    chk("stall_cycles", 128'(stall_cycles), 128'(stall_m));
  end

  // Transfer monitor just before each edge: pops on output transfer.
  always @(negedge clk) begin
    ent_t e;
    #3;
    if (!reset && enable) begin
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() > 0) begin
          if (out_ready) begin
            e = exp_q.pop_front();
            chk("pop_ctrl", 128'(out_ctrl), 128'(e.c));
            chk("pop_data", 128'(out_data), 128'(e.d));
          end else if (stall_m != 16'hFFFF) begin
            stall_m = stall_m + 16'd1;
          end
        end
        if (pend_v) exp_q.push_back(pend);
      end
      if (exp_q.size() > 0) last_data = exp_q[0].d;
    end
    pend_v = 1'b0;
  end

  task automatic drive(input logic v, input ent_t e, input logic ordy, input logic en,
                       input logic fl, output logic acc);
    logic pred;
    @(negedge clk);
    in_valid  = v;
    in_ctrl   = e.c;
    in_data   = e.d;
    out_ready = ordy;
    enable    = en;
    flush     = fl;
    #1;
    pred = !reset && en && !fl && (exp_q.size() < 2);
    chk("in_ready", 128'(in_ready), 128'(pred));
    acc = v && pred;
    if (acc) begin
      pend   = e;
      pend_v = 1'b1;
    end
  endtask

  task automatic send(input ent_t e, input logic ordy);
    logic acc;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      drive(1'b1, e, ordy, 1'b1, 1'b0, acc);
      n++;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got not-accepted expected accepted within 20 cycles");
    end
  endtask

  task automatic idle(input logic ordy, input int cycles);
    logic acc;
    ent_t z;
    z = '0;
    for (int i = 0; i < cycles; i++) drive(1'b0, z, ordy, 1'b1, 1'b0, acc);
  endtask

  initial begin
    logic acc;
    ent_t a, b, c, z;
    z = '0;
    idle(1'b1, 3);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    @(negedge clk);
    reset = 1'b0;

    // Streaming with out_ready high.
    a = mk(16'h0041);
    drive(1'b1, a, 1'b1, 1'b1, 1'b0, acc);
    chk("first_accept", 128'(acc), 128'(1));
    for (int i = 0; i < 4; i++) send(mk(16'($urandom)), 1'b1);
    idle(1'b1, 2);

    // Backpressure: B lands in skid, C held upstream.
    a = mk(16'h0041); b = mk(16'h0042); c = mk(16'h0043);
    send(a, 1'b1);
    send(b, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, c, 1'b0, 1'b1, 1'b0, acc);
    chk("bp_c_held", 128'(acc), 128'(0));
    send(c, 1'b1);
    idle(1'b1, 3);

    // Flush with a full stage and in_valid high.
    send(mk(16'h0051), 1'b0);
    send(mk(16'h0052), 1'b0);
    drive(1'b1, mk(16'h0053), 1'b1, 1'b1, 1'b1, acc);
    chk("flush_accept", 128'(acc), 128'(0));
    idle(1'b1, 2);

    // Freeze with enable low and out_ready low.
    send(mk(16'h0061), 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, mk(16'h0062), 1'b0, 1'b0, 1'b0, acc);
    idle(1'b1, 3);

    // Single-entry variant: in_ready follows out_ready in the same cycle.
    a = mk(16'h0071); b = mk(16'h0072);
    drive(1'b0, z, 1'b1, 1'b1, 1'b0, acc);
    s_valid = 1'b1; s_ctrl = a.c; s_data = a.d; s_ordy = 1'b0;
    #1 chk("s_ready_empty", 128'(s_ready), 128'(1));
    drive(1'b0, z, 1'b1, 1'b1, 1'b0, acc);
    s_ctrl = b.c; s_data = b.d;
    #1 chk("s_ready_stall", 128'(s_ready), 128'(0));
    chk("s_ctrl_a", 128'(s_octrl), 128'(a.c));
    chk("s_occ_1", 128'(s_occ), 128'(1));
    s_ordy = 1'b1;
    #1 chk("s_ready_follow", 128'(s_ready), 128'(1));
    drive(1'b0, z, 1'b1, 1'b1, 1'b0, acc);
    chk("s_ctrl_b", 128'(s_octrl), 128'(b.c));
    chk("s_data_b", 128'(s_odata), 128'(b.d));
    s_valid = 1'b0;
    drive(1'b0, z, 1'b1, 1'b1, 1'b0, acc);
    chk("s_bubble_valid", 128'(s_ovalid), 128'(0));
    chk("s_bubble_ctrl", 128'(s_octrl), 128'(0));
    chk("s_held_data", 128'(s_odata), 128'(b.d));

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(9) < 7), mk(16'($urandom)), ($urandom_range(9) < 6),
            ($urandom_range(9) != 0), ($urandom_range(99) < 3), acc);
    end
    idle(1'b1, 3);

    // Saturating stall counter, then reset between edges.
    send(mk(16'h0081), 1'b0);
    idle(1'b0, 70000);
    chk("stall_sat", 128'(stall_cycles), 128'(16'hFFFF));
    reset = 1'b1;
    exp_q.delete();
    pend_v = 1'b0;
    stall_m = '0;
    last_data = '0;
    #1;
    chk("arst_valid", 128'(out_valid), 128'(0));
    chk("arst_occ", 128'(occupancy), 128'(0));
    chk("arst_stall", 128'(stall_cycles), 128'(0));
    chk("arst_in_ready", 128'(in_ready), 128'(0));
    idle(1'b1, 2);
    @(negedge clk);
    reset = 1'b0;
    send(mk(16'h0091), 1'b1);
    idle(1'b1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised, elastic pipeline-stage register for the RV32IM core. It is the generic successor to the hand-written inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Payload is split into a control field and a data field. The control field is forced to a safe value on bubble and flush; the data field is held.
- Uses a valid/ready handshake with an optional skid entry, so ready can be registered.
- Counts backpressure cycles for performance debug.

Parameters:
DATA_W, 96, width of data payload (operands, immediates, PCs, instr).
CTRL_W, 16, width of control payload (reg_write, mem_read, branch, ...).
CTRL_RESET, 0, value driven on out_ctrl whenever the stage holds no valid entry.
SKID_EN, 1, 1 = two-entry (main + skid) with registered in_ready; 0 = single entry, combinational in_ready.
FLUSH_CLEARS_DATA, 0, 1 = flush also zeroes the data field of both entries.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  global run qualifier (core started and not done); low freezes all state.
flush  input  1  kill all held entries (branch mispredict / redirect).
in_valid  input  1  upstream has an entry.
in_ready  output  1  stage accepts an entry this cycle.
in_ctrl  input  CTRL_W  upstream control field.
in_data  input  DATA_W  upstream data field.
out_valid  output  1  main entry is valid.
out_ready  input  1  downstream consumes main entry (stall = low).
out_ctrl  output  CTRL_W  main control field; CTRL_RESET when out_valid=0.
out_data  output  DATA_W  main data field.
occupancy  output  2  number of valid entries (0..2).
stall_cycles  output  16  saturating count of backpressure cycles.

Behaviour:
- Reset (async, immediate):
  - out_valid=0, skid empty, out_ctrl=CTRL_RESET, out_data=0, occupancy=0, stall_cycles=0.
  - in_ready=0 while reset is asserted.
  - First acceptance is possible on the first edge after reset deasserts, with enable=1.
- enable=0:
  - No register changes.
  - in_ready=0.
  - Outputs hold.
  - stall_cycles does not count.
- Transfer rules:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Priority (enable=1): flush > advance/hold.
- Flush:
  - in_ready=0 combinationally during flush, so no input is accepted.
  - Next edge: out_valid=0, skid emptied, out_ctrl=CTRL_RESET.
  - out_data held unless FLUSH_CLEARS_DATA=1.
  - out_ready is ignored that cycle.
- SKID_EN=1:
  - in_ready = enable && !flush && !skid_valid. This depends on registered state only; there is no path from out_ready.
  - Main loads when (!out_valid || out_ready). Source is the skid entry if it is valid, else the input-transfer entry.
  - If main cannot load and an input transfer occurs, the entry goes to skid.
  - If main is consumed, skid is empty and there is no input transfer, the next cycle has out_valid=0. This is a bubble and out_ctrl=CTRL_RESET.
  - Order is strictly FIFO: the skid entry always exits before any later entry.
- SKID_EN=0:
  - in_ready = enable && !flush && (!out_valid || out_ready). This is a combinational path from out_ready.
  - There is no skid storage; occupancy is at most 1.
- out_ctrl is masked to CTRL_RESET whenever out_valid=0. out_data is never masked (it retains the last loaded value).
- occupancy = out_valid + skid_valid, registered.
- stall_cycles:
  - +1 on each edge with enable && !flush && out_valid && !out_ready.
  - Saturates at 16'hFFFF; does not wrap.
  - Cleared only by reset.
- Reset mid-operation:
  - All entries are lost immediately.
  - No partial transfer is completed.

Test Plan:
- Streaming, SKID_EN=1, out_ready=1: entries A(ctrl=16'h0041), B, C on consecutive cycles -> appear on out_* one cycle after acceptance, back-to-back. occupancy=1, in_ready constant 1.
- Backpressure: stream A,B,C with out_ready=0 from the cycle A appears -> B captured in skid. in_ready=0 next cycle, occupancy=2, C held upstream. Release out_ready -> outputs A,B,C in order with no loss or duplicate. stall_cycles equals the count of held cycles.
- Flush with full stage: occupancy=2, flush=1 with in_valid=1 -> in_ready=0 that cycle. Next cycle out_valid=0, out_ctrl=CTRL_RESET, occupancy=0, out_data unchanged (FLUSH_CLEARS_DATA=0).
- enable low: freeze mid-stream for 5 cycles with out_ready=0 -> all outputs constant, in_ready=0, stall_cycles does not increment.
- SKID_EN=0: out_valid=1, out_ready toggled 0->1 with in_valid=1 -> in_ready follows out_ready in the same cycle. The new entry replaces the old at that edge.
- Saturation and async reset: hold out_ready=0 for 70000 cycles -> stall_cycles=16'hFFFF. Assert reset between edges -> out_valid, occupancy and stall_cycles are 0 before the next clock edge.
